ds: RTL and testbench
=====================

# ds

Symbol-rate downsampler with phase acquisition for the baseband receive path. Accepts 2-bit signed samples at 4 samples per symbol, the format the transmit upsampler emits: one `{sign,1}` impulse per 4 cycles, zeros elsewhere. It finds which of the 4 sample phases carries the symbol and then emits one hard-decision symbol per period with a valid strobe. It sits between the channel/sample source and the symbol demapper.

## Interface
- `ACQ_SYM`, default 8: symbol periods accumulated during acquisition (1..255).
- `ERASE_MAX`, default 4: consecutive zero decisions in LOCK that force re-acquisition (1..15).

- `clk`, input, 1: single clock; all logic on rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `en`, input, 1: block enable; low aborts and restarts acquisition.
- `din`, input, 2: signed two's-complement sample (01=+1, 11=-1, 00=0, 10=-2).
- `dout`, output, 2: decided symbol `{sign,1}`, or 00 on erasure.
- `dvalid`, output, 1: one-cycle strobe, `dout` updated this cycle.
- `locked`, output, 1: high while in LOCK.

## Operation
- **Phase counter `cnt`** (2-bit): cleared to 0 on reset or when `en`=0. Otherwise it increments mod 4 each cycle. The `din` sampled at an edge with `en`=1 has phase `cnt`.
- **States:** ACQ (reset state) and LOCK.
- **ACQ:**
  - Four accumulators `E[0..3]`, each clog2(2*ACQ_SYM+1) bits. On each `en` cycle, `E[cnt] += |din|`, where |10|=2, |01|=|11|=1, |00|=0. Accumulators do not saturate; the width makes overflow impossible.
  - Symbol counter `sym` increments on each `cnt`==3 sample.
  - On the edge that accumulates the ACQ_SYM-th `cnt`==3 sample, `sel` gets the argmax of the updated `E` (lowest index on ties), state moves to LOCK, and `E` and `sym` clear.
  - If all `E` are 0 at that point, state stays in ACQ and accumulation restarts.
- **LOCK:**
  - On each `en` edge with `cnt`==`sel`, a decision is made.
  - `din`≠00: `dout` <= `{din[1],1'b1}`, erasure counter clears.
  - `din`=00: `dout` <= 00, erasure counter increments.
  - `dvalid` pulses on every decision.
  - When the erasure counter reaches ERASE_MAX, state returns to ACQ on that edge. The erasing decision is still output with `dvalid`=1, and `E`, `sym` and the erasure counter clear.
- **`en`=0:** `cnt`, `E`, `sym` and the erasure counter clear, state goes to ACQ, `dvalid`=0, `dout` holds its last value.
- **`reset`:** overrides everything, including `en` and mid-acquisition or mid-LOCK operation.

## Timing
- Reset values: `dout`=00, `dvalid`=0, `locked`=0, `cnt`=0, state ACQ, `sel`=0.
- Decision latency: 1 cycle. The `din` sampled at edge k appears on `dout`/`dvalid` after edge k.
- `locked` rises after the edge that completes acquisition. The first possible `dvalid` is the next edge with `cnt`==`sel`, i.e. 1–4 cycles later.
- In LOCK, `dvalid` is high exactly 1 of every 4 cycles while `en` stays high.
- Minimum time from `en` rising to first `dvalid`: 4*ACQ_SYM + 1 cycles. This occurs when `sel`=0.
- `en` deasserted for one cycle: `locked` falls after that edge, and `cnt` restarts at 0 on the next enabled edge.

## Configuration
- **`DS_ERASE_EN` defined:** erasure detection as specified. `din`=00 at the `sel` phase gives `dout`=00, and ERASE_MAX consecutive erasures trigger re-acquisition.
- **Not defined:**
  - `din`=00 at the `sel` phase decides as +1 (`dout`=01). `dout`=00 is never produced after reset.
  - No erasure counter. LOCK is left only via `en`=0 or `reset`.
  - ERASE_MAX is ignored.

## Test plan
- **Basic lock:** reset 2 cycles, then `en`=1 with the upsampler pattern at phase 3 (`din`=01 when `cnt`=3, else 00) for ACQ_SYM=8 periods. Required: `locked`=1 after cycle 32, `sel`=3, then `dvalid` every 4th cycle with `dout`=01.
- **Data decisions:** after lock at phase 1, drive symbols +1,-1,-1,+1 (01,11,11,01). Required: `dout` sequence 01,11,11,01, each with a single-cycle `dvalid`, 1 cycle after the sample.
- **Tie and all-zero:** equal energy on phases 0 and 2 gives `sel`=0. All-zero input for 8 periods keeps `locked`=0 and restarts acquisition.
- **Erasure (`DS_ERASE_EN`):** in LOCK, 4 consecutive 00 at `sel` give four `dout`=00 strobes, then `locked`=0 after the 4th. With only 3 erasures followed by 11, the bench sees `dout`=11 and `locked` stays 1. Without the macro, the same stimulus gives `dout`=01 and `locked` stays 1.
- **Abort:** pull `en` low for 1 cycle mid-LOCK, then hold `reset` high 1 cycle mid-ACQ. Required: `dout` holds and `locked`=0 after the `en` drop; all outputs read 00/0/0 after the reset edge; re-acquisition completes 32 cycles after `en` returns high.

Source files
------------

// File: rtl/ds.sv
// Symbol-rate downsampler: acquires the symbol phase of a 4x upsampled stream, then slices one symbol per period.
// Optional erasure detection and re-acquisition are built when DS_ERASE_EN is defined.
module ds #(
   parameter int unsigned ACQ_SYM   = 8,
   parameter int unsigned ERASE_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] din,
   output logic [1:0] dout,
   output logic       dvalid,
   output logic       locked
);

   localparam int unsigned EW = $clog2(2 * ACQ_SYM + 1);

   typedef enum logic {ACQ, LOCK} state_t;

   state_t        state;
   logic [1:0]    cnt;
   logic [1:0]    sel;
   logic [EW-1:0] e     [4];
   logic [EW-1:0] e_upd [4];
   logic [7:0]    sym;
   logic [1:0]    mag;
   logic [1:0]    best;
   logic          all_zero;
   logic          acq_done;

`ifdef DS_ERASE_EN
   localparam int unsigned ERS_W = 4;
   logic [ERS_W-1:0] ers;
`else
   logic unused_erase;
   assign unused_erase = (ERASE_MAX == 0);
`endif

   assign locked = (state == LOCK);

   // Accumulators are evaluated post-update so the final sample counts toward argmax.
   always_comb begin
      mag      = (din == 2'b10) ? 2'd2 : ((din == 2'b00) ? 2'd0 : 2'd1);
      all_zero = 1'b1;
      best     = 2'd0;
      for (int unsigned i = 0; i < 4; i++) begin
         e_upd[i] = e[i] + ((cnt == 2'(i)) ? EW'(mag) : EW'(0));
         if (e_upd[i] != '0) all_zero = 1'b0;
      end
      for (int unsigned i = 1; i < 4; i++) begin
         if (e_upd[i] > e_upd[best]) best = 2'(i);
      end
      acq_done = (cnt == 2'd3) && (sym == 8'(ACQ_SYM - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ACQ;
         cnt    <= '0;
         sel    <= '0;
         sym    <= '0;
         dout   <= '0;
         dvalid <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) e[i] <= '0;
`ifdef DS_ERASE_EN
         ers    <= '0;
`endif
      end else if (!en) begin
         state  <= ACQ;
         cnt    <= '0;
         sym    <= '0;
         dvalid <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) e[i] <= '0;
`ifdef DS_ERASE_EN
         ers    <= '0;
`endif
      end else begin
         cnt    <= cnt + 2'd1;
         dvalid <= 1'b0;
         case (state)
            ACQ: begin
               if (acq_done) begin
                  sym <= '0;
                  for (int unsigned i = 0; i < 4; i++) e[i] <= '0;
                  if (!all_zero) begin
                     sel   <= best;
                     state <= LOCK;
                  end
               end else begin
                  e <= e_upd;
                  if (cnt == 2'd3) sym <= sym + 8'd1;
               end
            end
            LOCK: begin
               if (cnt == sel) begin
                  dvalid <= 1'b1;
`ifdef DS_ERASE_EN
                  if (din == 2'b00) begin
                     dout <= 2'b00;
                     if (ers == ERS_W'(ERASE_MAX - 1)) begin
                        ers   <= '0;
                        state <= ACQ;
                     end else begin
                        ers <= ers + 1'b1;
                     end
                  end else begin
                     dout <= {din[1], 1'b1};
                     ers  <= '0;
                  end
`else
                  dout <= {din[1], 1'b1};
`endif
               end
            end
            default: state <= ACQ;
         endcase
      end
   end

endmodule

// File: tb/tb_ds.sv
// Self-checking bench for ds: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_ds;

   localparam int ACQ  = 8;
   localparam int EMAX = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [1:0] din = 2'b00;
   logic [1:0] dout;
   logic       dvalid;
   logic       locked;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int         m_n;
   int         m_energy [4];
   int         m_periods;
   bit         m_locked;
   int         m_sel;
   int         m_run;
   logic [1:0] m_dout;
   bit         m_dvalid;

   always #5 clk = ~clk;

   ds #(.ACQ_SYM(ACQ), .ERASE_MAX(EMAX)) dut (
      .clk(clk), .reset(reset), .en(en), .din(din),
      .dout(dout), .dvalid(dvalid), .locked(locked)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int magnitude(input logic [1:0] d);
      int v;
      v = $signed(d);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int phase();
      return m_n % 4;
   endfunction

   task automatic model_clear_acq();
      for (int k = 0; k < 4; k++) m_energy[k] = 0;
      m_periods = 0;
   endtask

   task automatic model_step(input logic r, input logic e, input logic [1:0] d);
      int ph;
      int best;
      if (r) begin
         m_n = 0; model_clear_acq(); m_locked = 0; m_sel = 0; m_run = 0;
         m_dout = 2'b00; m_dvalid = 0;
         return;
      end
      if (!e) begin
         m_n = 0; model_clear_acq(); m_locked = 0; m_run = 0; m_dvalid = 0;
         return;
      end
      ph = phase();
      m_n++;
      m_dvalid = 0;
      if (!m_locked) begin
         m_energy[ph] += magnitude(d);
         if (ph == 3) begin
            m_periods++;
            if (m_periods == ACQ) begin
               best = 0;
               for (int k = 1; k < 4; k++) if (m_energy[k] > m_energy[best]) best = k;
               if (m_energy[best] > 0) begin
                  m_locked = 1;
                  m_sel = best;
               end
               model_clear_acq();
            end
         end
      end else if (ph == m_sel) begin
         m_dvalid = 1;
`ifdef DS_ERASE_EN
         if (d == 2'b00) begin
            m_dout = 2'b00;
            m_run++;
            if (m_run == EMAX) begin
               m_locked = 0;
               m_run = 0;
               model_clear_acq();
            end
         end else begin
            m_dout = {d[1], 1'b1};
            m_run = 0;
         end
`else
         m_dout = (d == 2'b00) ? 2'b01 : {d[1], 1'b1};
`endif
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic [1:0] d);
      reset = r; en = e; din = d;
      @(posedge clk);
      model_step(r, e, d);
      #1;
      check("dout", dout, m_dout);
      check("dvalid", dvalid, m_dvalid);
      check("locked", locked, m_locked);
   endtask

   task automatic run_pat(input int n, input int p, input logic [1:0] v);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, (phase() == p) ? v : 2'b00);
   endtask

   initial begin
      int nv;
      logic [1:0] held;
      logic [1:0] syms [4];
      int         p;
      logic [1:0] d;
      logic       r;
      logic       e;

      // reset
      cyc(1'b1, 1'b0, 2'b00);
      cyc(1'b1, 1'b0, 2'b00);
      check("rst_dout", dout, 0);
      check("rst_dvalid", dvalid, 0);
      check("rst_locked", locked, 0);

      // basic lock at phase 3
      run_pat(31, 3, 2'b01);
      check("lock_before32", locked, 0);
      run_pat(1, 3, 2'b01);
      check("lock_at32", locked, 1);
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b1, (phase() == 3) ? 2'b01 : 2'b00);
         if (dvalid) begin
            nv++;
            check("basic_dout", dout, 1);
            check("basic_phase", (m_n - 1) % 4, 3);
         end
      end
      check("basic_rate", nv, 2);

      // data decisions at phase 1
      cyc(1'b0, 1'b0, 2'b00);
      run_pat(32, 1, 2'b01);
      check("lock_ph1", locked, 1);
      syms[0] = 2'b01; syms[1] = 2'b11; syms[2] = 2'b11; syms[3] = 2'b01;
      for (int s = 0; s < 4; s++) begin
         while (phase() != 1) cyc(1'b0, 1'b1, 2'b00);
         cyc(1'b0, 1'b1, syms[s]);
         check("data_dvalid", dvalid, 1);
         check("data_dout", dout, syms[s]);
         cyc(1'b0, 1'b1, 2'b00);
         check("data_pulse", dvalid, 0);
      end

      // tie between phases 0 and 2 resolves to 0
      cyc(1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, (phase() % 2 == 0) ? 2'b11 : 2'b00);
      check("tie_locked", locked, 1);
      cyc(1'b0, 1'b1, 2'b01);
      check("tie_sel0", dvalid, 1);

      // all-zero acquisition stays unlocked, then restarts cleanly
      cyc(1'b0, 1'b0, 2'b00);
      run_pat(32, 2, 2'b00);
      check("zero_unlocked", locked, 0);
      run_pat(32, 2, 2'b01);
      check("zero_relock", locked, 1);

      // four erasures at the sel phase
      for (int s = 0; s < 4; s++) begin
         while (phase() != 2) cyc(1'b0, 1'b1, 2'b00);
         cyc(1'b0, 1'b1, 2'b00);
         check("erase_dvalid", dvalid, 1);
`ifdef DS_ERASE_EN
         check("erase_dout", dout, 0);
         check("erase_locked", locked, (s == 3) ? 0 : 1);
`else
         check("erase_dout", dout, 1);
         check("erase_locked", locked, 1);
`endif
      end

      // three erasures then a -1 keep lock
      cyc(1'b0, 1'b0, 2'b00);
      run_pat(32, 2, 2'b01);
      for (int s = 0; s < 4; s++) begin
         while (phase() != 2) cyc(1'b0, 1'b1, 2'b00);
         cyc(1'b0, 1'b1, (s == 3) ? 2'b11 : 2'b00);
      end
      check("erase3_dout", dout, 3);
      check("erase3_locked", locked, 1);

      // abort: en low mid-LOCK, then reset mid-ACQ
      cyc(1'b0, 1'b1, 2'b00);
      held = dout;
      cyc(1'b0, 1'b0, 2'b00);
      check("abort_hold", dout, held);
      check("abort_locked", locked, 0);
      run_pat(16, 2, 2'b01);
      cyc(1'b1, 1'b1, 2'b01);
      check("abort_rst_dout", dout, 0);
      check("abort_rst_dvalid", dvalid, 0);
      check("abort_rst_locked", locked, 0);
      run_pat(31, 0, 2'b01);
      check("reacq_31", locked, 0);
      run_pat(1, 0, 2'b01);
      check("reacq_32", locked, 1);
      cyc(1'b0, 1'b1, 2'b11);
      check("reacq_first", dvalid, 1);

      // randomized traffic
      p = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 500 == 0) p = $urandom_range(0, 3);
         r = ($urandom_range(0, 999) == 0);
         e = ($urandom_range(0, 299) != 0);
         if (phase() == p) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3: d = 2'b01;
               4, 5, 6:    d = 2'b11;
               7:          d = 2'b10;
               default:    d = 2'b00;
            endcase
         end else begin
            d = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         end
         cyc(r, e, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
